// File: rtl/put_data_ddc_if.sv
// Stream handshake bundle (tdata/tvalid/tready) used on both sides of the
// DDC output pacing buffer. The master drives data and valid, the slave
// drives ready.
interface put_data_ddc_if #(
  parameter int N = 16
);
  logic [N-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/put_data_ddc.sv
// Output pacing buffer for the DDC path. Decimated samples arrive in bursts,
// are held in a small FIFO, and leave only in two fixed cadence slots per
// PERIOD-cycle frame. A downstream stall freezes the frame so the presented
// sample and its slot stay put until the handshake completes.
module put_data_ddc #(
  parameter int N       = 16,
  parameter int DEPTH   = 8,
  parameter int PERIOD  = 5,
  parameter int PHASE_A = 1,
  parameter int PHASE_B = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  put_data_ddc_if.slave            din,
  put_data_ddc_if.master           dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
  localparam logic [CW-1:0] SLOT_A     = CW'(PHASE_A);
  localparam logic [CW-1:0] SLOT_B     = CW'(PHASE_B);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [CW-1:0] cnt;

  logic slot;
  logic push;
  logic pop;
  logic stall;

  // Handshake decode: ready never falls through from a same-cycle pop, and
  // valid only shows up in a cadence slot with something buffered.
  always_comb begin
    slot        = (cnt == SLOT_A) || (cnt == SLOT_B);
    din.tready  = (level_q != FULL_LEVEL);
    dout.tvalid = slot && (level_q != '0);
    dout.tdata  = mem[rd_ptr];
    push        = din.tvalid && din.tready;
    pop         = dout.tvalid && dout.tready;
    stall       = dout.tvalid && !dout.tready;
    level       = level_q;
  end

  // Sample storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din.tdata;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the
  // occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Cadence counter: free-runs around the frame but holds while a presented
  // sample is being stalled, so the slot (and the data) stay presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!stall) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_put_data_ddc.sv
// Self-checking bench for put_data_ddc. Stimulus drives the input and output
// handshakes; a monitor on the falling edge keeps a reference model (a queue
// of accepted samples plus a frame position) and compares the DUT against it.
module tb_put_data_ddc;

  localparam int N       = 16;
  localparam int DEPTH   = 8;
  localparam int PERIOD  = 5;
  localparam int PHASE_A = 1;
  localparam int PHASE_B = 4;

  logic clk;
  logic rst_n;
  logic [$clog2(DEPTH):0] level;

  put_data_ddc_if #(.N(N)) din_if ();
  put_data_ddc_if #(.N(N)) dout_if ();

  put_data_ddc #(
    .N(N), .DEPTH(DEPTH), .PERIOD(PERIOD), .PHASE_A(PHASE_A), .PHASE_B(PHASE_B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din_if),
    .dout  (dout_if),
    .level (level)
  );

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] sb [$];
  int pos = 0;
  int emitted = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [N-1:0] d, input logic r);
    @(posedge clk);
    #1;
    din_if.tvalid  = v;
    din_if.tdata   = d;
    dout_if.tready = r;
  endtask

  // Reference model and checker: samples leave in acceptance order, occupancy
  // is the number held, a sample is shown only in slots PHASE_A/PHASE_B of the
  // frame, and the frame does not advance while a shown sample is refused.
  always @(negedge clk) begin
    logic expValid;
    logic expReady;
    logic doPush;
    logic doPop;
    if (!rst_n) begin
      sb.delete();
      pos = 0;
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_din_tready", 32'(din_if.tready), 32'd1);
      checkOutput("rst_dout_tvalid", 32'(dout_if.tvalid), 32'd0);
    end else begin
      expValid = ((pos == PHASE_A) || (pos == PHASE_B)) && (sb.size() != 0);
      expReady = (sb.size() != DEPTH);
      checkOutput("level", 32'(level), 32'(sb.size()));
      checkOutput("din_tready", 32'(din_if.tready), 32'(expReady));
      checkOutput("dout_tvalid", 32'(dout_if.tvalid), 32'(expValid));
      if (expValid) begin
        checkOutput("dout_tdata", 32'(dout_if.tdata), 32'(sb[0]));
      end
      doPush = din_if.tvalid && expReady;
      doPop  = expValid && dout_if.tready;
      if (doPop) begin
        void'(sb.pop_front());
        emitted++;
      end
      if (doPush) begin
        sb.push_back(din_if.tdata);
      end
      if (!(expValid && !dout_if.tready)) begin
        pos = (pos + 1) % PERIOD;
      end
    end
  end

  // An asynchronous reset empties the model at once, whatever the clock is doing.
  always @(negedge rst_n) begin
    sb.delete();
    pos = 0;
  end

  initial begin
    int budget;
    rst_n          = 1'b0;
    din_if.tvalid  = 1'b0;
    din_if.tdata   = '0;
    dout_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] three back-to-back pushes");
    applyStimulus(1'b1, 16'h0001, 1'b1);
    applyStimulus(1'b1, 16'h0002, 1'b1);
    applyStimulus(1'b1, 16'h0003, 1'b1);
    repeat (12) applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("burst3_emitted", 32'(emitted), 32'd3);

    $display("[TB] fill with output blocked, then pop while full");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 16'(16'h0010 + i), 1'b0);
    end
    repeat (2) applyStimulus(1'b1, 16'hDEAD, 1'b0);
    applyStimulus(1'b1, 16'h0100, 1'b1);
    applyStimulus(1'b1, 16'h0101, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (45) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] stall in slot");
    applyStimulus(1'b1, 16'h0A5A, 1'b0);
    repeat (12) applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (10) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] simultaneous push and pop");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'(16'h0300 + i), 1'b1);
    end
    repeat (30) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] async reset mid-stall");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'(16'h0200 + i), 1'b0);
    end
    repeat (3) applyStimulus(1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_level", 32'(level), 32'd0);
    checkOutput("async_rst_dout_tvalid", 32'(dout_if.tvalid), 32'd0);
    checkOutput("async_rst_din_tready", 32'(din_if.tready), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    din_if.tvalid  = 1'b1;
    din_if.tdata   = 16'h0042;
    dout_if.tready = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    #4;
    checkOutput("post_rst_tvalid", 32'(dout_if.tvalid), 32'd1);
    checkOutput("post_rst_tdata", 32'(dout_if.tdata), 32'h0042);
    repeat (6) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'($urandom_range(0, 2) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    budget = 0;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    while (sb.size() != 0 && budget < 200) begin
      applyStimulus(1'b0, 16'h0000, 1'b1);
      budget++;
    end
    @(negedge clk);
    checkOutput("final_drain_empty", 32'(sb.size()), 32'd0);
    checkOutput("final_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
